// File: rtl/dm_pkg.sv
// Shared constants and FSM state encoding for the data-memory DMA engine.
// The FILL state exists only when DM_DMA_FILL_EN is defined.
package dm_pkg;

   localparam int DM_AW = 10;
   localparam int DM_DW = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
`ifdef DM_DMA_FILL_EN
      S_FILL,
`endif
      S_DONE
   } dm_state_e;

endpackage

// File: rtl/dm_dma_if.sv
// Request and data-memory signals of the DMA engine; master = the engine,
// slave = the requester plus the memory it drives.
interface dm_dma_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          start;
   logic          mode;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic [DW-1:0] fill_data;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_we;
   logic [DW-1:0] mem_dout;

   modport master (
      input  start, mode, src, dst, len, fill_data, mem_dout,
      output busy, done, mem_addr, mem_din, mem_we
   );

   modport slave (
      output start, mode, src, dst, len, fill_data, mem_dout,
      input  busy, done, mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/dm_dma.sv
// Word-copy DMA over a single-port data memory, 2 cycles per word (read, write).
// Define DM_DMA_FILL_EN to add a 1-cycle-per-word pattern fill (mode=1).
module dm_dma
   import dm_pkg::*;
#(
   parameter int AW = DM_AW,
   parameter int DW = DM_DW
) (
   input logic         clk,
   input logic         rst,
   dm_dma_if.master    bus
);

   dm_state_e     state_q;
   logic [AW-1:0] src_q, dst_q, src_d, dst_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] data_q;
   logic          busy_q, done_q, we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] din_q;
   logic          last;
`ifdef DM_DMA_FILL_EN
   logic [DW-1:0] fill_q;
`endif

   // Pointers wrap naturally at 2^AW.
   assign src_d = src_q + 1'b1;
   assign dst_d = dst_q + 1'b1;
   assign cnt_d = cnt_q - 1'b1;
   assign last  = (cnt_q == {{AW{1'b0}}, 1'b1});

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.mem_we   = we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = din_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
`ifdef DM_DMA_FILL_EN
         fill_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  src_q <= bus.src;
                  dst_q <= bus.dst;
                  cnt_q <= bus.len;
`ifdef DM_DMA_FILL_EN
                  fill_q <= bus.fill_data;
`endif
                  if (bus.len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
`ifdef DM_DMA_FILL_EN
                  end else if (bus.mode) begin
                     state_q <= S_FILL;
                     busy_q  <= 1'b1;
                     we_q    <= 1'b1;
                     addr_q  <= bus.dst;
                     din_q   <= bus.fill_data;
`endif
                  end else begin
                     state_q <= S_RD;
                     busy_q  <= 1'b1;
                     addr_q  <= bus.src;
                  end
               end
            end
            S_RD: begin
               data_q  <= bus.mem_dout;
               din_q   <= bus.mem_dout;
               addr_q  <= dst_q;
               we_q    <= 1'b1;
               state_q <= S_WR;
            end
            S_WR: begin
               src_q <= src_d;
               dst_q <= dst_d;
               cnt_q <= cnt_d;
               we_q  <= 1'b0;
               if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_RD;
                  addr_q  <= src_d;
               end
            end
`ifdef DM_DMA_FILL_EN
            S_FILL: begin
               dst_q <= dst_d;
               cnt_q <= cnt_d;
               if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  we_q    <= 1'b0;
                  din_q   <= data_q;
               end else begin
                  addr_q <= dst_d;
                  din_q  <= fill_q;
               end
            end
`endif
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_dma.sv
// Directed bench for dm_dma with a behavioural 1K-word data memory.
module tb_dm_dma;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dm_dma_if #(.AW(10), .DW(32)) bus ();
   dm_dma #(.AW(10), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] mem [0:1023];
   logic [9:0]  wa [$];
   logic [31:0] wd [$];
   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   int b0;

   assign bus.mem_dout = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr] = bus.mem_din;
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_din);
      end
   end

   always @(negedge clk) if (bus.busy) busy_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(tag, bus.done, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
      bus.len = '0; bus.fill_data = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 | i;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_we",   bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_din",  bus.mem_din, 0);
      @(negedge clk) rst = 1'b0;

      // basic copy: 1,2 -> 10,11
      mem[1] = 32'h1; mem[2] = 32'h67;
      wa.delete(); wd.delete();
      bus.src = 10'd1; bus.dst = 10'd10; bus.len = 11'd2;
      b0 = busy_cnt;
      pulse_start();
      chk("cp_rd_addr", bus.mem_addr, 10'd1);
      chk("cp_rd_we", bus.mem_we, 0);
      wait_done("cp_done");
      chk("cp_busy_cycles", busy_cnt - b0, 4);
      chk("cp_m10", mem[10], 32'h1);
      chk("cp_m11", mem[11], 32'h67);
      chk("cp_nwr", wa.size(), 2);
      chk("cp_done_addr_hold", bus.mem_addr, 10'd11);
      @(negedge clk);
      chk("cp_done_width", bus.done, 0);
      chk("cp_idle_din_hold", bus.mem_din, 32'h67);
      chk("cp_idle_addr_hold", bus.mem_addr, 10'd11);

      // zero length
      wa.delete(); wd.delete();
      bus.src = 10'd3; bus.dst = 10'd30; bus.len = 11'd0;
      b0 = busy_cnt;
      pulse_start();
      chk("len0_done_next", bus.done, 1);
      @(negedge clk);
      chk("len0_done_width", bus.done, 0);
      @(negedge clk);
      chk("len0_no_we", wa.size(), 0);
      chk("len0_busy", busy_cnt - b0, 0);

      // wrap across the top; a second start mid-transfer must be ignored
      mem[1022] = 32'hAAAA0001; mem[1023] = 32'hAAAA0002;
      mem[0] = 32'hAAAA0003; mem[1] = 32'hAAAA0004;
      wa.delete(); wd.delete();
      bus.src = 10'd1022; bus.dst = 10'd100; bus.len = 11'd4;
      b0 = busy_cnt;
      pulse_start();
      @(negedge clk);
      bus.start = 1'b1; bus.src = 10'd500; bus.dst = 10'd600; bus.len = 11'd1;
      @(negedge clk) bus.start = 1'b0;
      wait_done("wr_done");
      chk("wr_busy_cycles", busy_cnt - b0, 8);
      chk("wr_nwr", wa.size(), 4);
      if (wa.size() == 4) begin
         chk("wr_a0", wa[0], 10'd100); chk("wr_d0", wd[0], 32'hAAAA0001);
         chk("wr_a1", wa[1], 10'd101); chk("wr_d1", wd[1], 32'hAAAA0002);
         chk("wr_a2", wa[2], 10'd102); chk("wr_d2", wd[2], 32'hAAAA0003);
         chk("wr_a3", wa[3], 10'd103); chk("wr_d3", wd[3], 32'hAAAA0004);
      end
      chk("wr_m600_untouched", mem[600], 32'hDEAD0258);
      @(negedge clk);

      // fill (or copy from src=200 when the fill option is absent)
      mem[200] = 32'h11; mem[201] = 32'h22; mem[202] = 32'h33;
      wa.delete(); wd.delete();
      bus.mode = 1'b1; bus.src = 10'd200; bus.dst = 10'd5; bus.len = 11'd3;
      bus.fill_data = 32'hA5A5A5A5;
      b0 = busy_cnt;
      pulse_start();
      wait_done("fl_done");
`ifdef DM_DMA_FILL_EN
      chk("fl_busy_cycles", busy_cnt - b0, 3);
      chk("fl_m5", mem[5], 32'hA5A5A5A5);
      chk("fl_m6", mem[6], 32'hA5A5A5A5);
      chk("fl_m7", mem[7], 32'hA5A5A5A5);
`else
      chk("fl_busy_cycles", busy_cnt - b0, 6);
      chk("fl_m5", mem[5], 32'h11);
      chk("fl_m6", mem[6], 32'h22);
      chk("fl_m7", mem[7], 32'h33);
`endif
      chk("fl_m8_untouched", mem[8], 32'hDEAD0008);
      bus.mode = 1'b0;
      @(negedge clk);

      // reset during the second WR of a 5-word copy
      for (int i = 0; i < 5; i++) mem[300+i] = 32'hC0DE0000 | i;
      wa.delete(); wd.delete();
      bus.src = 10'd300; bus.dst = 10'd400; bus.len = 11'd5;
      pulse_start();
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("rs_pre_we", bus.mem_we, 1);
      chk("rs_pre_addr", bus.mem_addr, 10'd401);
      #2 rst = 1'b1;
      #1;
      chk("rs_we_drop", bus.mem_we, 0);
      chk("rs_busy", bus.busy, 0);
      chk("rs_addr", bus.mem_addr, 0);
      chk("rs_din", bus.mem_din, 0);
      @(negedge clk); @(negedge clk);
      chk("rs_m400_kept", mem[400], 32'hC0DE0000);
      chk("rs_m401_unwritten", mem[401], 32'hDEAD0191);
      chk("rs_nwr", wa.size(), 1);
      rst = 1'b0;

      // normal run after reset release
      mem[50] = 32'h5A5A0050;
      bus.src = 10'd50; bus.dst = 10'd20; bus.len = 11'd1;
      b0 = busy_cnt;
      pulse_start();
      wait_done("pr_done");
      chk("pr_busy_cycles", busy_cnt - b0, 2);
      chk("pr_m20", mem[20], 32'h5A5A0050);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_dma.md
DM_DMA -- requirements
Module: dm_dma

Interface
REQ-001 The parameter list SHALL be: AW, 10, word-address width matching the data memory's addr[11:2].
REQ-002 The parameter list SHALL include: DW, 32, data word width.
REQ-003 The ports SHALL include: clk  input  1  single clock, rising-edge.
REQ-004 The ports SHALL include: rst  input  1  reset, asynchronous, active-high.
REQ-005 The ports SHALL include: start  input  1  request strobe, sampled on the rising clk edge.
REQ-006 The ports SHALL include: mode  input  1  0 = copy, 1 = fill.
REQ-007 The ports SHALL include: src  input  AW  source word address.
REQ-008 The ports SHALL include: dst  input  AW  destination word address.
REQ-009 The ports SHALL include: len  input  AW+1  word count, 0..1024.
REQ-010 The ports SHALL include: fill_data  input  DW  fill pattern.
REQ-011 The ports SHALL include: busy  output  1  transfer in progress.
REQ-012 The ports SHALL include: done  output  1  one-cycle completion pulse.
REQ-013 The ports SHALL include: mem_addr  output  AW  drives the data memory addr[11:2].
REQ-014 The ports SHALL include: mem_din  output  DW  write data to memory.
REQ-015 The ports SHALL include: mem_we  output  1  memory write enable (memwr).
REQ-016 The ports SHALL include: mem_dout  input  DW  memory read data, combinational from mem_addr.

Function
REQ-017 The state machine SHALL have the states IDLE, RD, WR, FILL and DONE.
REQ-018 In IDLE, start=1 SHALL latch src, dst, len, mode and fill_data, then move to RD (copy) or FILL (fill); if len=0 it SHALL move to DONE.
REQ-019 RD SHALL drive mem_addr=src_ptr and mem_we=0, capture mem_dout into a data register at the clock edge, and move to WR.
REQ-020 WR SHALL drive mem_addr=dst_ptr, mem_din=data register and mem_we=1, then increment both pointers and decrement the count; it SHALL move to DONE if the count reaches 0, else to RD.
REQ-021 A copy SHALL take 2 cycles per word; for N words, busy SHALL be high for exactly 2N cycles.
REQ-022 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-023 busy SHALL be 1 only in RD, WR and FILL.
REQ-024 mem_we SHALL be 1 only in WR and FILL.
REQ-025 The pointers SHALL wrap modulo 2^AW: 1023+1 -> 0.
REQ-026 start while not in IDLE SHALL be ignored, with no effect on the latched operands.
REQ-027 Overlapping regions SHALL be copied strictly in ascending word order, one word at a time; no hazard correction is made.
REQ-028 In IDLE and DONE, mem_we SHALL be 0, mem_addr SHALL hold its last value, and mem_din SHALL hold the data register.

Reset
REQ-029 rst=1 SHALL immediately force, asynchronously: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0, and pointers, count and data register = 0.
REQ-030 Reset mid-transfer SHALL abort the transfer with no further write; any words already written SHALL remain in memory.

Configuration
REQ-031 With DM_DMA_FILL_EN defined, mode=1 SHALL select FILL: each cycle mem_addr=dst_ptr, mem_din=fill_data and mem_we=1, at 1 cycle per word with no reads; it SHALL move to DONE after len words.
REQ-032 Without DM_DMA_FILL_EN, the FILL state and the fill_data register SHALL be absent, mode SHALL be ignored, and every request SHALL be a copy; the ports SHALL remain.

Structure
REQ-033 A shared package dm_pkg SHALL hold the AW/DW constants and the state encoding typedef.
REQ-034 The design SHALL be a single module with no sub-module; dm_4k is the peer in the bench only.

Verification
REQ-035 Copy: preload mem[1]=0x1 and mem[2]=0x67; start with src=1, dst=10, len=2 -> writes 10<-0x1 and 11<-0x67, busy=1 for 4 cycles, then done for 1 cycle.
REQ-036 len=0: start -> done pulses on the next cycle and mem_we never asserts.
REQ-037 Wrap: src=1022, dst=100, len=4 -> reads 1022, 1023, 0, 1 in order into 100..103.
REQ-038 Fill (with DM_DMA_FILL_EN): dst=5, len=3, fill_data=0xA5A5A5A5 -> mem[5..7] written, busy=1 for 3 cycles; without the macro, the same stimulus performs a copy.
REQ-039 Busy/reset: start during a transfer is ignored; asserting rst between clock edges during WR drops mem_we at once, and a new start after release runs normally.
